bpsk_tx_shaper: RTL and testbench

- Transmit-side counterpart of the slicer: maps input bits to BPSK symbols (+1/−1) and produces OS-times oversampled, pulse-shaped samples through a polyphase FIR.
- Sits between the bit source and the channel/RX filter.
- Emits o_sync symbol-alignment strobes in the same convention the slicer's i_sync consumes.

---
 rtl/bpsk_tx_shaper.sv | 140 ++++++++++++++
 tb/tb_bpsk_tx_shaper.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bpsk_tx_shaper.sv
`default_nettype none
// ============================================================================
// Module   : bpsk_tx_shaper
// Purpose  : BPSK transmit pulse shaper. Each bit becomes a +1/-1 symbol
//            (bit 0 -> +1, bit 1 -> -1) and is fed to an OS-times
//            oversampling polyphase FIR with a saturated registered output.
//            A symbol-alignment strobe (o_sync) marks phase-0 samples.
// Options  : TX_PRBS_EN - when defined, an internal PRBS9 (x^9+x^5+1,
//            seed 9'h1FF) supplies the data bits and i_bit is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module bpsk_tx_shaper #(
  parameter int OS     = 4,
  parameter int TAPS   = 6,
  parameter int S_COEF = 8,
  parameter int S_OUT  = 10,
  // Default: a single 127 at coef[OS*(TAPS/2)], everything else zero.
  parameter logic [OS*TAPS*S_COEF-1:0] COEF =
    {{((OS*TAPS - OS*(TAPS/2) - 1)*S_COEF){1'b0}},
     S_COEF'(127),
     {(OS*(TAPS/2)*S_COEF){1'b0}}}
) (
  input  logic                    clock,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic                    i_valid,
  input  logic                    i_bit,
  output logic signed [S_OUT-1:0] o_data,
  output logic                    o_valid,
  output logic                    o_sync
);

  localparam int PW    = (OS > 1) ? $clog2(OS) : 1;
  localparam int IW    = $clog2(OS*TAPS);
  // Full-precision accumulator width, widened to at least the output width
  // so the clamp comparisons are always meaningful.
  localparam int ACC_W = S_COEF + $clog2(TAPS) + 1;
  localparam int SUM_W = (ACC_W > S_OUT) ? ACC_W : S_OUT;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (S_OUT-1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(1 << (S_OUT-1)));
  localparam logic [PW-1:0] LAST_PHASE = PW'(OS - 1);

  logic [PW-1:0]             phase;
  logic [TAPS-1:0]           sym_neg;    // 1 = symbol is -1, 0 = +1
  logic [TAPS-1:0]           occ;        // tap holds a real symbol
  logic [TAPS-1:0]           sym_nxt;
  logic [TAPS-1:0]           occ_nxt;
  logic                      accept;
  logic                      at_sym;
  logic                      new_bit;
  logic signed [SUM_W-1:0]   acc;
  logic signed [SUM_W-1:0]   term;
  logic [IW-1:0]             idx;
  logic signed [S_OUT-1:0]   sat_val;
  logic signed [S_COEF-1:0]  coef_tab [OS*TAPS];

  // Unpack the flat coefficient vector into an addressable table.
  for (genvar n = 0; n < OS*TAPS; n++) begin : g_coef
    assign coef_tab[n] = COEF[n*S_COEF +: S_COEF];
  end

  assign accept = i_enable & i_valid;
  assign at_sym = accept && (phase == '0);

`ifdef TX_PRBS_EN
  logic [8:0] lfsr;
  logic       unused_bit;

  assign unused_bit = i_bit;
  assign new_bit    = lfsr[8];

  // PRBS9 source: steps once per symbol entry, output taken from bit 8.
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      lfsr <= 9'h1FF;
    end else if (at_sym) begin
      lfsr <= {lfsr[7:0], lfsr[8] ^ lfsr[4]};
    end
  end
`else
  assign new_bit = i_bit;
`endif

  // Post-shift symbol/occupancy view, so a bit entered on this strobe
  // already contributes as the newest tap.
  always_comb begin
    sym_nxt = sym_neg;
    occ_nxt = occ;
    if (at_sym) begin
      sym_nxt = {sym_neg[TAPS-2:0], new_bit};
      occ_nxt = {occ[TAPS-2:0], 1'b1};
    end
  end

  // Polyphase dot product for the current phase, then clamp to S_OUT.
  always_comb begin
    acc     = '0;
    term    = '0;
    idx     = '0;
    sat_val = '0;
    for (int k = 0; k < TAPS; k++) begin
      idx  = IW'(k*OS + int'(phase));
      term = {{(SUM_W-S_COEF){coef_tab[idx][S_COEF-1]}}, coef_tab[idx]};
      if (occ_nxt[k]) begin
        acc = sym_nxt[k] ? (acc - term) : (acc + term);
      end
    end
    if (acc > SAT_MAX) begin
      sat_val = SAT_MAX[S_OUT-1:0];
    end else if (acc < SAT_MIN) begin
      sat_val = SAT_MIN[S_OUT-1:0];
    end else begin
      sat_val = acc[S_OUT-1:0];
    end
  end

  // Phase, symbol history and registered outputs; reset wins over enable.
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      phase   <= '0;
      sym_neg <= '0;
      occ     <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_sync  <= 1'b0;
    end else if (accept) begin
      phase   <= (phase == LAST_PHASE) ? '0 : phase + PW'(1);
      sym_neg <= sym_nxt;
      occ     <= occ_nxt;
      o_data  <= sat_val;
      o_valid <= 1'b1;
      o_sync  <= (phase == '0);
    end else begin
      o_valid <= 1'b0;
      o_sync  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bpsk_tx_shaper.sv
`default_nettype none
// ============================================================================
// Module   : tb_bpsk_tx_shaper
// Purpose  : Directed bench for bpsk_tx_shaper. A default-coefficient
//            instance and an all-127 instance share the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bpsk_tx_shaper;

  localparam logic [191:0] ALL127 = {24{8'd127}};

  logic              clock    = 1'b0;
  logic              i_reset  = 1'b0;
  logic              i_enable = 1'b0;
  logic              i_valid  = 1'b0;
  logic              i_bit    = 1'b0;
  logic signed [9:0] o_data;
  logic              o_valid;
  logic              o_sync;
  logic signed [9:0] sat_data;
  logic              sat_valid;
  logic              sat_sync;

  int    checks   = 0;
  int    failures = 0;
  string step     = "init";

  bpsk_tx_shaper dut (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .i_valid  (i_valid),
    .i_bit    (i_bit),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_sync   (o_sync)
  );

  bpsk_tx_shaper #(.COEF(ALL127)) dut_sat (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .i_valid  (i_valid),
    .i_bit    (i_bit),
    .o_data   (sat_data),
    .o_valid  (sat_valid),
    .o_sync   (sat_sync)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s: observed %0d expected %0d", step, tag, obs, exp);
    end
  endtask

  // One accepted strobe, then check both instances.
  task automatic strobe(input logic b, input int ed, input int es, input int esat);
    i_enable = 1'b1;
    i_valid  = 1'b1;
    i_bit    = b;
    @(posedge clock);
    #1;
    i_valid  = 1'b0;
    chk("valid", int'(o_valid), 1);
    chk("sync", int'(o_sync), es);
    chk("data", int'(o_data), ed);
    chk("sat_data", int'(sat_data), esat);
  endtask

  // Full symbol: bit b at phase 0, inverted bit offered at phases 1..3.
  task automatic sym(input logic b, input int exp0, input int esat);
    strobe(b, exp0, 1, esat);
    for (int p = 1; p < 4; p++) strobe(~b, 0, 0, esat);
  endtask

  // Idle cycle: no strobe, outputs must hold.
  task automatic gap(input int ed, input int esat);
    i_enable = 1'b1;
    i_valid  = 1'b0;
    i_bit    = 1'b1;
    @(posedge clock);
    #1;
    chk("gap_valid", int'(o_valid), 0);
    chk("gap_sync", int'(o_sync), 0);
    chk("gap_data", int'(o_data), ed);
    chk("gap_sat", int'(sat_data), esat);
  endtask

  // Disabled cycle with a strobe offered: must be ignored.
  task automatic freeze(input int ed, input int esat);
    i_enable = 1'b0;
    i_valid  = 1'b1;
    i_bit    = 1'b1;
    @(posedge clock);
    #1;
    i_enable = 1'b1;
    i_valid  = 1'b0;
    chk("frz_valid", int'(o_valid), 0);
    chk("frz_sync", int'(o_sync), 0);
    chk("frz_data", int'(o_data), ed);
    chk("frz_sat", int'(sat_data), esat);
  endtask

  initial begin
    // Reset held 2 cycles with strobes offered: reset must dominate.
    step     = "reset";
    i_reset  = 1'b0;
    i_enable = 1'b1;
    i_valid  = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("valid", int'(o_valid), 0);
    chk("sync", int'(o_sync), 0);
    chk("data", int'(o_data), 0);
    chk("sat_data", int'(sat_data), 0);
    i_reset = 1'b1;
    i_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("post_valid", int'(o_valid), 0);
    chk("post_data", int'(o_data), 0);

    // Fill with zeros: delta appears at symbol 3; sum ramps and saturates.
    step = "fill";
    sym(1'b0,    0, 127);
    sym(1'b0,    0, 254);
    sym(1'b0,    0, 381);
    sym(1'b0,  127, 508);
    sym(1'b0,  127, 511);
    sym(1'b0,  127, 511);

    // Ones: window drifts from +762 to -762, clamped at -512.
    step = "sat";
    sym(1'b1,  127,  508);
    sym(1'b1,  127,  254);
    sym(1'b1,  127,    0);
    sym(1'b1, -127, -254);
    sym(1'b1, -127, -508);
    sym(1'b1, -127, -512);

    // Partial symbol then reset at phase 2.
    step = "midrst";
    strobe(1'b0, -127, 1, -508);
    strobe(1'b1,    0, 0, -508);
    i_reset  = 1'b0;
    i_enable = 1'b1;
    i_valid  = 1'b1;
    i_bit    = 1'b1;
    @(posedge clock);
    #1;
    chk("valid", int'(o_valid), 0);
    chk("sync", int'(o_sync), 0);
    chk("data", int'(o_data), 0);
    chk("sat_data", int'(sat_data), 0);
    i_reset = 1'b1;
    i_valid = 1'b0;

    // Mapping after reset: history gone, phase restarts at 0.
    step = "map";
    sym(1'b1,    0, -127);
    sym(1'b0,    0,    0);
    sym(1'b1,    0, -127);
    sym(1'b1, -127, -254);
    sym(1'b0,  127, -127);
    sym(1'b0, -127,    0);
    sym(1'b0, -127,  254);
    sym(1'b0,  127,  254);

    // Strobe gaps in a 1,1,0,0 rhythm: outputs hold, phase only on strobes.
    step = "gap";
    strobe(1'b0, 127, 1, 508);
    gap(127, 508);
    gap(127, 508);
    strobe(1'b1, 0, 0, 508);
    strobe(1'b1, 0, 0, 508);
    gap(0, 508);
    gap(0, 508);
    strobe(1'b1, 0, 0, 508);
    sym(1'b1, 127, 508);

    // Enable freeze for 5 cycles right after a phase-0 sample.
    step = "freeze";
    strobe(1'b0, 127, 1, 508);
    repeat (5) freeze(127, 508);
    for (int p = 1; p < 4; p++) strobe(1'b1, 0, 0, 508);
    sym(1'b0,  127, 508);
    sym(1'b0, -127, 508);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
